// File: rtl/dcm_lock_ctrl_pkg.sv
// Shared types and constants for the DCM_SP lock sequencing controller.
package dcm_ctrl_pkg;

    // FSM states, binary encoded
    typedef enum logic [2:0] {
        ST_RST_PULSE = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_READY     = 3'd3,
        ST_FAIL      = 3'd4
    } dcm_state_e;

    // DCM_SP STATUS bus bit positions
    localparam int DCM_ST_CLKIN_STOP = 1;
    localparam int DCM_ST_CLKFX_STOP = 2;

    // Width of the shared cycle counter
    localparam int CNT_W = 16;

    // Saturating increment for the 4-bit retry counter
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/dcm_lock_ctrl_if.sv
// Control/status bundle between the lock controller and its surroundings.
// slave: the controller side; master: the DCM/system side driving it.
interface dcm_lock_ctrl_if;
    logic       restart;
    logic       locked;
    logic [7:0] dcm_status;
    logic       dcm_reset;
    logic       clk_ready;
    logic       lock_fail;
    logic [3:0] retry_cnt;
    logic [7:0] relock_cnt;

    modport slave (
        input  restart, locked, dcm_status,
        output dcm_reset, clk_ready, lock_fail, retry_cnt, relock_cnt
    );

    modport master (
        output restart, locked, dcm_status,
        input  dcm_reset, clk_ready, lock_fail, retry_cnt, relock_cnt
    );
endinterface

// File: rtl/dcm_lock_ctrl_sync2_ff.sv
// Two-flop synchronizer of configurable width, synchronously cleared.
module sync2_ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    // Two-stage capture of an asynchronous input
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/dcm_lock_ctrl.sv
// DCM_SP lock sequencing controller: reset pulse, lock wait with timeout,
// stability qualification, then clk_ready; re-sequences on loss of lock.
// Optional: define DCM_CLKFX_MON_EN to also treat STATUS[2] (CLKFX stopped)
// as loss of lock in READY and as a qualification restart in STABLE.
module dcm_lock_ctrl
    import dcm_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = 8,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int STABLE_CYCLES = 1023,
    parameter int MAX_RETRY     = 7
) (
    input logic             clk,
    input logic             reset,
    dcm_lock_ctrl_if.slave  bus
);
    localparam logic [CNT_W-1:0] RST_TC    = CNT_W'(RST_CYCLES);
    localparam logic [CNT_W-1:0] LOCK_TC   = CNT_W'(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] STABLE_TC = CNT_W'(STABLE_CYCLES);
    localparam logic [3:0]       RETRY_LIM = 4'(MAX_RETRY);

    dcm_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             dcm_reset_q, clk_ready_q, lock_fail_q;
    logic [3:0]       retry_q;
    logic [7:0]       relock_q;
    logic             locked_s, clkin_stop, clkfx_stop;
    logic             loss_evt;
    logic [3:0]       retry_nxt;

    sync2_ff #(.W(1)) u_lock_sync (
        .clk(clk), .reset(reset), .d(bus.locked), .q(locked_s)
    );

`ifdef DCM_CLKFX_MON_EN
    logic [1:0] st_s;
    sync2_ff #(.W(2)) u_status_sync (
        .clk(clk), .reset(reset),
        .d({bus.dcm_status[DCM_ST_CLKFX_STOP], bus.dcm_status[DCM_ST_CLKIN_STOP]}),
        .q(st_s)
    );
    assign clkin_stop = st_s[0];
    assign clkfx_stop = st_s[1];
    logic unused_status;
    assign unused_status = ^{bus.dcm_status[7:3], bus.dcm_status[0]};
`else
    sync2_ff #(.W(1)) u_status_sync (
        .clk(clk), .reset(reset),
        .d(bus.dcm_status[DCM_ST_CLKIN_STOP]), .q(clkin_stop)
    );
    assign clkfx_stop = 1'b0;
    logic unused_status;
    assign unused_status = ^{bus.dcm_status[7:2], bus.dcm_status[0]};
`endif

    // Loss of a qualified clock; counted even when restart overrides the move
    assign loss_evt  = (state == ST_READY) && (!locked_s || clkin_stop || clkfx_stop);
    assign retry_nxt = sat_inc4(retry_q);

    // Sequencing FSM with registered outputs; restart overrides every transition
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RST_PULSE;
            cnt         <= '0;
            dcm_reset_q <= 1'b1;
            clk_ready_q <= 1'b0;
            lock_fail_q <= 1'b0;
            retry_q     <= '0;
            relock_q    <= '0;
        end else begin
            if (loss_evt)
                relock_q <= relock_q + 8'd1;
            if (bus.restart) begin
                state       <= ST_RST_PULSE;
                cnt         <= '0;
                retry_q     <= '0;
                lock_fail_q <= 1'b0;
                clk_ready_q <= 1'b0;
                dcm_reset_q <= 1'b1;
            end else begin
                case (state)
                    ST_RST_PULSE: begin
                        if (cnt == RST_TC) begin
                            state       <= ST_WAIT_LOCK;
                            cnt         <= '0;
                            dcm_reset_q <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (locked_s) begin
                            state <= ST_STABLE;
                            cnt   <= '0;
                        end else if (cnt == LOCK_TC) begin
                            cnt         <= '0;
                            retry_q     <= retry_nxt;
                            dcm_reset_q <= 1'b1;
                            if (retry_nxt >= RETRY_LIM) begin
                                state       <= ST_FAIL;
                                lock_fail_q <= 1'b1;
                            end else begin
                                state <= ST_RST_PULSE;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_STABLE: begin
                        if (!locked_s) begin
                            state <= ST_WAIT_LOCK;
                            cnt   <= '0;
                        end else if (clkfx_stop) begin
                            cnt <= '0;
                        end else if (cnt == STABLE_TC) begin
                            state       <= ST_READY;
                            cnt         <= '0;
                            clk_ready_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_READY: begin
                        if (loss_evt) begin
                            state       <= ST_RST_PULSE;
                            cnt         <= '0;
                            clk_ready_q <= 1'b0;
                            dcm_reset_q <= 1'b1;
                        end
                    end
                    ST_FAIL: begin
                        dcm_reset_q <= 1'b1;
                        lock_fail_q <= 1'b1;
                    end
                    default: begin
                        state       <= ST_RST_PULSE;
                        cnt         <= '0;
                        dcm_reset_q <= 1'b1;
                        clk_ready_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.dcm_reset  = dcm_reset_q;
    assign bus.clk_ready  = clk_ready_q;
    assign bus.lock_fail  = lock_fail_q;
    assign bus.retry_cnt  = retry_q;
    assign bus.relock_cnt = relock_q;
endmodule
